tt_um_akaur014_parity_tx: RTL and testbench

//  Serial transmitter feeding the 3-bit-group Mealy odd-parity checker: emits a continuous

---
 rtl/tt_um_akaur014_parity_tx.sv | 86 ++++++++
 tb/tb_tt_um_akaur014_parity_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_akaur014_parity_tx.sv
// tt_um_akaur014_parity_tx: continuous odd-parity 3-bit frame transmitter (d0, d1, p) with a one-entry hold register.
// Optional TX_ERR_INJECT_EN: ui_in[3] marks a held frame to be sent with inverted parity.
module tt_um_akaur014_parity_tx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
`ifdef TX_ERR_INJECT_EN
   localparam int SW = 4;
`else
   localparam int SW = 3;
`endif
   typedef enum logic [1:0] {IDLE, B0, B1, BP} state_t;
   state_t                            r_state, w_next;
   logic [SYNC_STAGES-1:0][SW-1:0]    r_sync;
   logic [SW-1:0]                     w_syn;
   logic                              r_prev, r_full, r_filler, r_line, r_ovf;
   logic [1:0]                        r_hold, r_frame, w_frame_n;
   logic [CNT_W-1:0]                  r_cnt;
   logic                              w_load, w_b0, w_avail, w_line_n, w_flip, w_unused;
   assign w_syn    = r_sync[SYNC_STAGES-1];
   assign w_load   = w_syn[2] & ~r_prev;
   assign w_unused = &{1'b0, ena, uio_in, ui_in[7:SW]};
   always_comb begin
      w_next    = r_state == B0 ? B1 : r_state == B1 ? BP : B0;
      w_b0      = w_next == B0;
      w_avail   = ~r_full | w_b0;
      w_frame_n = w_b0 ? (r_full ? r_hold : 2'b00) : r_frame;
      w_line_n  = w_next == B0 ? w_frame_n[0] :
                  w_next == B1 ? w_frame_n[1] : ~(w_frame_n[0] ^ w_frame_n[1]) ^ w_flip;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sync   <= '0;
         r_prev   <= 1'b0;
         r_hold   <= 2'b00;
         r_full   <= 1'b0;
         r_frame  <= 2'b00;
         r_filler <= 1'b0;
         r_line   <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_next;
         r_sync   <= {r_sync[SYNC_STAGES-2:0], ui_in[SW-1:0]};
         r_prev   <= w_syn[2];
         r_frame  <= w_frame_n;
         r_filler <= w_b0 ? ~r_full : r_filler;
         r_line   <= w_line_n;
         // a frame boundary frees the slot, so a load on the same edge still fits
         if (w_load & w_avail) begin
            r_hold <= w_syn[1:0];
            r_full <= 1'b1;
         end else if (w_b0) r_full <= 1'b0;
         if (w_load & ~w_avail) r_ovf <= 1'b1;
         if (w_next == BP && !r_filler) r_cnt <= r_cnt + 1'b1;
      end
   end
`ifdef TX_ERR_INJECT_EN
   logic r_inj, r_finj;
   assign w_flip = w_b0 ? (r_full & r_inj) : r_finj;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inj  <= 1'b0;
         r_finj <= 1'b0;
      end else begin
         r_finj <= w_flip;
         if (w_load & w_avail) r_inj <= w_syn[3];
      end
   end
`else
   assign w_flip = 1'b0;
`endif
   assign uo_out  = {r_cnt[2:0], r_ovf, ~r_full, r_filler, r_state == B0, r_line};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_akaur014_parity_tx.sv
// tb_tt_um_akaur014_parity_tx: directed loads; expected frames queued at issue, checked by a frame monitor.
module tb_tt_um_akaur014_parity_tx;
   logic       clk = 1'b0, rst_n = 1'b1, ena = 1'b1;
   logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;
   int         n_run = 0, n_fail = 0, n_fill = 0, pos = -1, f0;
   logic [2:0] q[$];
   logic [2:0] fb;
   logic       ff;

   tt_um_akaur014_parity_tx dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // frames are recognised by frame_start; line bits collected first-bit-in-MSB
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) pos = -1;
      else if (uo_out[1]) begin
         pos   = 0;
         fb[2] = uo_out[0];
         ff    = uo_out[2];
      end else if (pos >= 0) begin
         pos++;
         fb[2-pos] = uo_out[0];
         if (pos == 2) begin
            chk("filler_flag_steady", uo_out[2], ff);
            if (ff) begin
               n_fill++;
               chk("filler_frame", fb, 3'b001);
            end else if (q.size() == 0) begin
               n_run++;
               n_fail++;
               $display("FAIL unexpected_data_frame: got %b expected none", fb);
            end else chk("data_frame", fb, q.pop_front());
            pos = -1;
         end
      end
   end

   task automatic step(input logic s, input logic [1:0] d, input logic inj);
      ui_in = {4'b0000, inj, s, d};
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_uo_out", uo_out, 8'h08);
      chk("reset_uio_out", uio_out, 8'h00);
      chk("reset_uio_oe", uio_oe, 8'h00);
      rst_n = 1'b1;
   endtask

   task automatic sync_b0();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (uo_out[1]) return;
      end
      chk("sync_b0_timeout", 1, 0);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (q.size() == 0) return;
      end
      chk("drain_timeout", q.size(), 0);
      q.delete();
   endtask

   logic [1:0] dv[4] = '{2'b01, 2'b11, 2'b00, 2'b10};
   logic [2:0] ev[4] = '{3'b100, 3'b111, 3'b001, 3'b010};

   initial begin
      // idle line: fillers only
      do_reset();
      f0 = n_fill;
      @(negedge clk);
      chk("first_edge_uo_out", uo_out, 8'h0E);
      repeat (12) @(negedge clk);
      chk("t1_fillers", n_fill - f0, 4);
      chk("t1_count", uo_out[7:5], 0);
      // single load
      do_reset();
      sync_b0();
      step(1'b1, 2'b10, 1'b0);
      q.push_back(3'b010);
      step(1'b0, 2'b00, 1'b0);
      wait_empty();
      chk("t2_count", uo_out[7:5], 1);
      repeat (6) @(negedge clk);
      chk("t2_count_hold", uo_out[7:5], 1);
      // back-to-back loads every 3 cycles
      do_reset();
      sync_b0();
      f0 = n_fill;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, dv[i], 1'b0);
         q.push_back(ev[i]);
         step(1'b0, 2'b00, 1'b0);
         step(1'b0, 2'b00, 1'b0);
      end
      wait_empty();
      chk("t3_leading_fillers_only", n_fill - f0, 2);
      chk("t3_count", uo_out[7:5], 4);
      // overflow: second load while hold full away from a boundary
      do_reset();
      sync_b0();
      step(1'b1, 2'b01, 1'b0);
      q.push_back(3'b100);
      step(1'b0, 2'b00, 1'b0);
      step(1'b1, 2'b11, 1'b0);
      step(1'b0, 2'b00, 1'b0);
      chk("t4_ovf_before", uo_out[4], 0);
      chk("t4_ready_full", uo_out[3], 0);
      @(negedge clk);
      chk("t4_ovf_set", uo_out[4], 1);
      chk("t4_ready_low", uo_out[3], 0);
      wait_empty();
      chk("t4_count", uo_out[7:5], 1);
      chk("t4_ovf_sticky", uo_out[4], 1);
      // load coinciding with the boundary that drains a full hold
      do_reset();
      sync_b0();
      step(1'b1, 2'b01, 1'b0);
      q.push_back(3'b100);
      step(1'b0, 2'b00, 1'b0);
      step(1'b0, 2'b00, 1'b0);
      step(1'b1, 2'b10, 1'b0);
      q.push_back(3'b010);
      step(1'b0, 2'b00, 1'b0);
      chk("t5_ready_full", uo_out[3], 0);
      @(negedge clk);
      chk("t5_ready_reloaded", uo_out[3], 0);
      chk("t5_no_ovf", uo_out[4], 0);
      wait_empty();
      chk("t5_count", uo_out[7:5], 2);
      chk("t5_no_ovf_end", uo_out[4], 0);
      // parity inject flag (ignored unless the feature is built in)
      do_reset();
      sync_b0();
      step(1'b1, 2'b11, 1'b1);
`ifdef TX_ERR_INJECT_EN
      q.push_back(3'b110);
`else
      q.push_back(3'b111);
`endif
      step(1'b0, 2'b00, 1'b0);
      step(1'b0, 2'b00, 1'b0);
      step(1'b1, 2'b11, 1'b0);
      q.push_back(3'b111);
      step(1'b0, 2'b00, 1'b0);
      wait_empty();
      repeat (4) @(negedge clk);
      chk("t6_count", uo_out[7:5], 2);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
